// File: rtl/pipe_spawner.sv
// rtl/pipe_spawner.sv - scrolls up to NUM_PIPES pipe words per frame, spawns new pipes, pulses score
// Define PIPE_RANDOM_GAP_EN to take the gap centre from a 16-bit LFSR instead of SCREEN_HEIGHT/2.
module pipe_spawner #(
  parameter int NUM_PIPES      = 3,
  parameter int SCREEN_WIDTH   = 640,
  parameter int SCREEN_HEIGHT  = 480,
  parameter int PIPE_WIDTH     = 70,
  parameter int GAP_HEIGHT     = 120,
  parameter int GAP_MIN_Y      = 120,
  parameter int GAP_MAX_Y      = 360,
  parameter int SCROLL_SPEED   = 2,
  parameter int SPAWN_INTERVAL = 90,
  parameter int BIRD_X         = 160
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   frame_tick,
  output logic [32*NUM_PIPES-1:0] pipe_regs,
  output logic                   busy,
  output logic                   score_pulse
);

  localparam int IW = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
  localparam int CW = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCROLL = 2'd1,
    SPAWN  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           score_q, score_d;
  logic [31:0]    slot_q [NUM_PIPES];
  logic [31:0]    slot_d [NUM_PIPES];

  logic [31:0]    cur;
  logic [31:0]    cur_next;
  logic [10:0]    left_ext;
  logic [10:0]    right_ext;
  logic           found;
  logic [8:0]     centre;
  logic [31:0]    spawn_word;

`ifdef PIPE_RANDOM_GAP_EN
  logic [15:0]    lfsr_q;
  logic [9:0]     centre_sum;

  // Free-running so the gap sequence depends on how long the player idles.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign centre_sum = 10'(GAP_MIN_Y) + {2'b00, lfsr_q[7:0]};
  assign centre     = (centre_sum > 10'(GAP_MAX_Y)) ? 9'(GAP_MAX_Y) : centre_sum[8:0];
`else
  assign centre     = 9'(SCREEN_HEIGHT / 2);
`endif

  assign spawn_word = {4'b0000, 9'(GAP_HEIGHT), centre, 10'(SCREEN_WIDTH)};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      score_q <= 1'b0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      score_q <= score_d;
      for (int i = 0; i < NUM_PIPES; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    score_d   = 1'b0;
    cur       = '0;
    cur_next  = '0;
    left_ext  = '0;
    right_ext = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      slot_d[i] = slot_q[i];
    end

    case (state_q)
      IDLE: begin
        if (frame_tick && enable) begin
          state_d = SCROLL;
          idx_d   = '0;
        end
      end

      SCROLL: begin
        for (int i = 0; i < NUM_PIPES; i++) begin
          if (idx_q == IW'(i)) cur = slot_q[i];
        end
        left_ext  = {1'b0, cur[9:0]};
        right_ext = left_ext + 11'(PIPE_WIDTH);
        if (cur != '0) begin
          // Scoring looks at the pre-move position, even for a pipe being retired now.
          score_d = (right_ext >= 11'(BIRD_X)) &&
                    ((right_ext - 11'(SCROLL_SPEED)) < 11'(BIRD_X));
          if (left_ext < 11'(SCROLL_SPEED)) begin
            cur_next = '0;
          end else begin
            cur_next = {cur[31:10], cur[9:0] - 10'(SCROLL_SPEED)};
          end
          for (int i = 0; i < NUM_PIPES; i++) begin
            if (idx_q == IW'(i)) slot_d[i] = cur_next;
          end
        end
        if (idx_q == IW'(NUM_PIPES - 1)) begin
          state_d = SPAWN;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end

      SPAWN: begin
        state_d = IDLE;
        if (cnt_q == CW'(SPAWN_INTERVAL - 1)) begin
          cnt_d = '0;
          // Slots already hold this sweep's results, so a just-retired slot is reusable.
          for (int i = 0; i < NUM_PIPES; i++) begin
            if (!found && (slot_q[i] == '0)) begin
              slot_d[i] = spawn_word;
              found     = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pack
    assign pipe_regs[32*g +: 32] = slot_q[g];
  end

  assign busy        = (state_q != IDLE);
  assign score_pulse = score_q;

endmodule
